// File: rtl/dm_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores over a word-only memory.
// Sub-word stores are done as read-modify-write; the core is stalled until completion.
module dm_access_unit #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        dm_re,
    input  logic [1:0]        dm_wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [2:0] DMRE_NOP = 3'd0;
    localparam logic [2:0] DMRE_LB  = 3'd1;
    localparam logic [2:0] DMRE_LBU = 3'd2;
    localparam logic [2:0] DMRE_LH  = 3'd3;
    localparam logic [2:0] DMRE_LHU = 3'd4;
    localparam logic [2:0] DMRE_LW  = 3'd5;

    localparam logic [1:0] DMWR_NOP = 2'd0;
    localparam logic [1:0] DMWR_SB  = 2'd1;
    localparam logic [1:0] DMWR_SH  = 2'd2;
    localparam logic [1:0] DMWR_SW  = 2'd3;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      state;
    logic [2:0]  re_q;
    logic [1:0]  wr_q;
    logic [1:0]  lane_q;
    logic [31:0] din_q;
    logic [31:0] cnt;

    logic        rd_valid;
    logic        wr_valid;
    logic        accept;
    logic        misalign;
    logic        timeout_hit;
    logic [7:0]  lane_byte;
    logic [15:0] half_word;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Address bits above the memory window are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    always_comb begin
        rd_valid = (dm_re == DMRE_LB) || (dm_re == DMRE_LBU) || (dm_re == DMRE_LH) ||
                   (dm_re == DMRE_LHU) || (dm_re == DMRE_LW);
        wr_valid = (dm_wr != DMWR_NOP);
        accept   = rd_valid || wr_valid;
        if (rd_valid) begin
            misalign = (((dm_re == DMRE_LH) || (dm_re == DMRE_LHU)) && addr[0]) ||
                       ((dm_re == DMRE_LW) && (addr[1:0] != 2'b00));
        end else begin
            misalign = ((dm_wr == DMWR_SH) && addr[0]) ||
                       ((dm_wr == DMWR_SW) && (addr[1:0] != 2'b00));
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && ((cnt + 32'd1) == 32'(TIMEOUT));

    // Load extraction and store merge both work on the word returned by the read.
    always_comb begin
        lane_byte = 8'(mem_rdata >> {lane_q, 3'b000});
        half_word = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (re_q)
            DMRE_LB:  load_val = {{24{lane_byte[7]}}, lane_byte};
            DMRE_LBU: load_val = {24'h0, lane_byte};
            DMRE_LH:  load_val = {{16{half_word[15]}}, half_word};
            DMRE_LHU: load_val = {16'h0, half_word};
            default:  load_val = mem_rdata;
        endcase
        merged = mem_rdata;
        if (wr_q == DMWR_SB) begin
            merged[{lane_q, 3'b000} +: 8] = din_q[7:0];
        end else if (wr_q == DMWR_SH) begin
            merged[{lane_q[1], 4'b0000} +: 16] = din_q[15:0];
        end
    end

    assign stall = rstn && ((state == StRd) || (state == StWr) || ((state == StIdle) && accept));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= StIdle;
            re_q      <= DMRE_NOP;
            wr_q      <= DMWR_NOP;
            lane_q    <= 2'b00;
            din_q     <= 32'h0;
            cnt       <= 32'h0;
            dout      <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        re_q   <= rd_valid ? dm_re : DMRE_NOP;
                        wr_q   <= rd_valid ? DMWR_NOP : dm_wr;
                        lane_q <= addr[1:0];
                        din_q  <= din;
                        if (misalign) begin
                            state <= StDone;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            dout  <= 32'h0;
                        end else begin
                            cnt      <= 32'h0;
                            mem_req  <= 1'b1;
                            mem_addr <= addr[ADDR_W+1:2];
                            if (!rd_valid && (dm_wr == DMWR_SW)) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= din;
                                state     <= StWr;
                            end else begin
                                mem_we <= 1'b0;
                                state  <= StRd;
                            end
                        end
                    end
                end
                StRd: begin
                    if (mem_ack) begin
                        if (re_q != DMRE_NOP) begin
                            mem_req <= 1'b0;
                            dout    <= load_val;
                            done    <= 1'b1;
                            state   <= StDone;
                        end else begin
                            cnt       <= 32'h0;
                            mem_we    <= 1'b1;
                            mem_wdata <= merged;
                            state     <= StWr;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dout    <= 32'h0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= StDone;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StWr: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dout    <= 32'h0;
                        done    <= 1'b1;
                        state   <= StDone;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dout    <= 32'h0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= StDone;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    // The op is still on the inputs here; it must not be taken again.
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: a driver pushes model expectations, a monitor
// checks each done pulse and a memory responder checks every committed write.
module tb_dm_access_unit;
    localparam int AW = 10;
    localparam int TO = 4;
    localparam int NWORDS = 1 << AW;

    localparam logic [2:0] RE_NOP = 3'd0, RE_LB = 3'd1, RE_LBU = 3'd2, RE_LH = 3'd3,
                           RE_LHU = 3'd4, RE_LW = 3'd5;
    localparam logic [1:0] WR_NOP = 2'd0, WR_SB = 2'd1, WR_SH = 2'd2, WR_SW = 2'd3;

    logic          clk, rstn;
    logic [2:0]    dm_re;
    logic [1:0]    dm_wr;
    logic [31:0]   addr, din, dout;
    logic          stall, done, err;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    dm_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dm_re(dm_re), .dm_wr(dm_wr), .addr(addr), .din(din),
        .dout(dout), .stall(stall), .done(done), .err(err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] dout; logic err; int stalls;} exp_t;
    typedef struct {int idx; logic [31:0] data;} wr_t;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    int   stall_cnt = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_sim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Memory responder: acks after ack_delay waiting cycles, commits and checks writes.
    always @(negedge clk) begin
        if (mem_req && rstn) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                wait_cnt  = 0;
                mem_rdata = mem[mem_addr];
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", {22'h0, mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        wr_t w;
                        w = wr_q.pop_front();
                        check("write_addr", {22'h0, mem_addr}, 32'(w.idx));
                        check("write_data", mem_wdata, w.data);
                    end
                    mem[mem_addr] = mem_wdata;
                end
            end else begin
                mem_ack   = 1'b0;
                wait_cnt++;
                mem_rdata = ~mem[mem_addr] ^ 32'h5A5A_A5A5;
            end
        end else begin
            mem_ack   = 1'b0;
            wait_cnt  = 0;
            mem_rdata = 32'h0BAD_0BAD;
        end
    end

    // Monitor: counts stall cycles and checks every completion against the scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_cnt = 0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", dout, e.dout);
                check("err", 32'(err), 32'(e.err));
                check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                check("stall_in_done", 32'(stall), 32'h0);
                check("req_in_done", 32'(mem_req), 32'h0);
            end
            stall_cnt = 0;
        end else if (stall) begin
            stall_cnt++;
        end
    end

    // Reference model: byte-addressed view of a little-endian word memory.
    task automatic model(input logic [2:0] re, input logic [1:0] wr, input logic [31:0] a,
                         input logic [31:0] d, input int dly, output exp_t e);
        int idx, k, size, v;
        logic [31:0] word, mask, nw;
        bit is_rd;
        idx   = int'(a[AW+1:2]);
        k     = int'(a[1:0]);
        word  = ref_mem[idx];
        is_rd = (re >= RE_LB) && (re <= RE_LW);
        if (is_rd) size = (re == RE_LW) ? 4 : ((re == RE_LH || re == RE_LHU) ? 2 : 1);
        else       size = (wr == WR_SW) ? 4 : ((wr == WR_SH) ? 2 : 1);
        e.dout = 32'h0;
        e.err  = 1'b0;
        if (k % size != 0) begin
            e.err    = 1'b1;
            e.stalls = 1;
            return;
        end
        if (dly >= TO) begin
            e.err    = 1'b1;
            e.stalls = 1 + TO;
            return;
        end
        if (is_rd) begin
            e.stalls = 2 + dly;
            v = int'((word >> (8 * k)) & ((size == 1) ? 32'hFF : 32'hFFFF));
            case (re)
                RE_LB:   e.dout = 32'((v >= 128) ? v - 256 : v);
                RE_LH:   e.dout = 32'((v >= 32768) ? v - 65536 : v);
                RE_LW:   e.dout = word;
                default: e.dout = 32'(v);
            endcase
        end else begin
            if (size == 4) begin
                e.stalls = 2 + dly;
                nw = d;
            end else begin
                e.stalls = 1 + 2 * (dly + 1);
                mask = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * k);
                nw = (word & ~mask) | ((d << (8 * k)) & mask);
            end
            ref_mem[idx] = nw;
            wr_q.push_back('{idx: idx, data: nw});
        end
    endtask

    task automatic do_op(input logic [2:0] re, input logic [1:0] wr, input logic [31:0] a,
                         input logic [31:0] d, input int dly, input bit use_c = 1'b0,
                         input logic [31:0] c_dout = 32'h0, input logic c_err = 1'b0);
        exp_t e;
        int n;
        model(re, wr, a, d, dly, e);
        if (use_c) begin
            e.dout = c_dout;
            e.err  = c_err;
        end
        @(posedge clk); #1;
        dm_re = re; dm_wr = wr; addr = a; din = d; ack_delay = dly;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            n_fail++;
            $display("FAIL done_wait: no done after %0d cycles, expected a completion", n);
            finish_sim();
        end
        @(posedge clk); #1;
        dm_re = RE_NOP; dm_wr = WR_NOP;
    endtask

    initial begin
        rstn = 1'b0; dm_re = RE_NOP; dm_wr = WR_NOP; addr = 32'h0; din = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_maddr", {22'h0, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Word load with immediate ack, then RMW byte store and reloads.
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = mem[4];
        do_op(RE_LW, WR_NOP, 32'h10, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        mem[4] = 32'h1122_3344; ref_mem[4] = mem[4];
        do_op(RE_NOP, WR_SB, 32'h13, 32'h55, 0);
        check("sb_mem", mem[4], 32'h5522_3344);
        do_op(RE_LBU, WR_NOP, 32'h13, 32'h0, 0, 1'b1, 32'h55, 1'b0);
        do_op(RE_LB, WR_NOP, 32'h13, 32'h0, 1, 1'b1, 32'h55, 1'b0);

        // Halfword store and sign-extending reload.
        mem[8] = 32'hAAAA_BBBB; ref_mem[8] = mem[8];
        do_op(RE_NOP, WR_SH, 32'h22, 32'h8001, 1);
        check("sh_mem", mem[8], 32'h8001_BBBB);
        do_op(RE_LH, WR_NOP, 32'h22, 32'h0, 0, 1'b1, 32'hFFFF_8001, 1'b0);

        mem[20] = 32'h8070_F0A1; ref_mem[20] = mem[20];
        do_op(RE_LB, WR_NOP, 32'h51, 32'h0, 0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        do_op(RE_LHU, WR_NOP, 32'h52, 32'h0, 2, 1'b1, 32'h0000_8070, 1'b0);

        // Misaligned accesses never touch memory.
        do_op(RE_NOP, WR_SW, 32'h06, 32'h1234_5678, 0, 1'b1, 32'h0, 1'b1);
        do_op(RE_LH, WR_NOP, 32'h05, 32'h0, 0, 1'b1, 32'h0, 1'b1);

        // Timeout abort, then an ack just inside the limit.
        do_op(RE_LW, WR_NOP, 32'h40, 32'h0, 100, 1'b1, 32'h0, 1'b1);
        do_op(RE_LW, WR_NOP, 32'h40, 32'h0, 3, 1'b1, ref_mem[16], 1'b0);

        // Reset while a byte store is waiting on its read.
        @(posedge clk); #1;
        dm_wr = WR_SB; addr = 32'h31; din = 32'hAB; ack_delay = 100;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_req_before", 32'(mem_req), 32'h1);
        rstn = 1'b0; dm_wr = WR_NOP;
        @(negedge clk);
        check("rst_mid_req", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_req_after", 32'(mem_req), 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_mem", mem[12], ref_mem[12]);
        do_op(RE_LW, WR_NOP, 32'h30, 32'h0, 0);

        // Randomized mix over a small address window to exercise read-after-write.
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  re;
            logic [1:0]  wr;
            logic [31:0] a;
            int dly;
            re  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 5)) : RE_NOP;
            wr  = 2'($urandom_range(0, 3));
            if (re == RE_NOP && wr == WR_NOP) wr = WR_SB;
            a   = {$urandom_range(0, 65535), 10'h0, 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            do_op(re, wr, a, $urandom, dly);
        end

        repeat (3) @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        check("write_queue_empty", 32'(wr_q.size()), 32'h0);
        finish_sim();
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        n_fail++;
        finish_sim();
    end
endmodule
